// File: rtl/traceback_unit.sv
// Traceback walker for an (N+1)x(N+1) alignment direction matrix, (N,N) to (0,0).
// Define TRACEBACK_ERR_CHECK_EN to flag invalid codes instead of coercing them.
module traceback_unit #(
    parameter int N = 5,
    parameter int addr_lenght = $clog2((N+1)*(N+1)-1),
    parameter int IW = $clog2(N+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [2:0]       dout,
    output logic                    en_dout,
    output logic [addr_lenght:0]    addr_dout,
    output logic                    step_valid,
    input  logic                    step_ready,
    output logic [2:0]              step_dir,
    output logic [IW-1:0]           step_i,
    output logic [IW-1:0]           step_j,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int AW = addr_lenght + 1;
    localparam logic [2:0] DIAG = 3'b001;
    localparam logic [2:0] UP   = 3'b010;
    localparam logic [2:0] LEFT = 3'b100;

    typedef enum logic [2:0] {IDLE, RD, CAP, EMIT, FIN} state_t;

    state_t        state;
    logic [IW-1:0] i_q;
    logic [IW-1:0] j_q;
    logic [IW-1:0] ni;
    logic [IW-1:0] nj;
    logic [2:0]    code;
    logic [2:0]    cap_dir;
    logic          onehot;
    logic          cap_bad;

    function automatic logic [AW-1:0] addr_of(
        input logic [IW-1:0] r,
        input logic [IW-1:0] c
    );
        return AW'(r) * AW'(N + 1) + AW'(c);
    endfunction

    assign step_i = i_q;
    assign step_j = j_q;

    always_comb begin
        code    = $unsigned(dout);
        onehot  = (code == DIAG) || (code == UP) || (code == LEFT);
        cap_dir = onehot ? code : DIAG;
    end

`ifdef TRACEBACK_ERR_CHECK_EN
    // Reads only happen with i>0 and j>0, but keep the underflow check explicit.
    assign cap_bad = !onehot
                   || ((code[0] || code[1]) && (i_q == '0))
                   || ((code[0] || code[2]) && (j_q == '0));
`else
    assign cap_bad = 1'b0;
    assign error   = 1'b0;
`endif

    // Index update for the presented step; saturates at zero.
    always_comb begin
        ni = i_q;
        nj = j_q;
        if ((step_dir[0] || step_dir[1]) && (i_q != '0))
            ni = i_q - IW'(1);
        if ((step_dir[0] || step_dir[2]) && (j_q != '0))
            nj = j_q - IW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            addr_dout  <= '0;
            en_dout    <= 1'b0;
            step_valid <= 1'b0;
            step_dir   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef TRACEBACK_ERR_CHECK_EN
            error      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RD;
                        i_q       <= IW'(N);
                        j_q       <= IW'(N);
                        addr_dout <= addr_of(IW'(N), IW'(N));
                        en_dout   <= 1'b1;
                        busy      <= 1'b1;
`ifdef TRACEBACK_ERR_CHECK_EN
                        error     <= 1'b0;
`endif
                    end
                end
                RD: begin
                    en_dout <= 1'b0;
                    state   <= CAP;
                end
                CAP: begin
                    if (cap_bad) begin
`ifdef TRACEBACK_ERR_CHECK_EN
                        error <= 1'b1;
`endif
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        step_dir   <= cap_dir;
                        step_valid <= 1'b1;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (step_ready) begin
                        i_q <= ni;
                        j_q <= nj;
                        if ((ni == '0) && (nj == '0)) begin
                            step_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= FIN;
                        end else if (ni == '0) begin
                            step_dir <= LEFT;
                        end else if (nj == '0) begin
                            step_dir <= UP;
                        end else begin
                            step_valid <= 1'b0;
                            en_dout    <= 1'b1;
                            addr_dout  <= addr_of(ni, nj);
                            state      <= RD;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit: table of expected steps per scenario,
// plus hand sequences for back-pressure and mid-run reset.
module tb_traceback_unit;

    localparam int N  = 5;
    localparam int AL = $clog2((N+1)*(N+1)-1);
    localparam int IW = $clog2(N+1);
    localparam logic [2:0] DIAG = 3'b001;
    localparam logic [2:0] UP   = 3'b010;
    localparam logic [2:0] LEFT = 3'b100;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              step_ready = 1'b0;
    logic signed [2:0] dout;
    logic              en_dout;
    logic [AL:0]       addr_dout;
    logic              step_valid;
    logic [2:0]        step_dir;
    logic [IW-1:0]     step_i;
    logic [IW-1:0]     step_j;
    logic              busy;
    logic              done;
    logic              error;

    logic [2:0] mem [0:(N+1)*(N+1)-1];

    typedef struct {
        int         scen;
        int         i;
        int         j;
        logic [2:0] d;
    } vec_t;

    typedef struct {
        int         i;
        int         j;
        logic [2:0] d;
    } step_t;

    vec_t  tbl[$];
    step_t got[$];
    int    passed = 0;
    int    total = 0;
    int    n_busy, n_en, n_col0, n_done;
    bit    tmo;

    traceback_unit #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dout(dout),
        .en_dout(en_dout),
        .addr_dout(addr_dout),
        .step_valid(step_valid),
        .step_ready(step_ready),
        .step_dir(step_dir),
        .step_i(step_i),
        .step_j(step_j),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en_dout) dout <= $signed(mem[addr_dout]);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic fill(input logic [2:0] c);
        for (int k = 0; k < (N+1)*(N+1); k++) mem[k] = c;
    endtask

    task automatic put(input int i, input int j, input logic [2:0] c);
        mem[i*(N+1)+j] = c;
    endtask

    task automatic run();
        got.delete();
        n_busy = 0;
        n_en = 0;
        n_col0 = 0;
        n_done = 0;
        tmo = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!busy) begin
                tmo = 1'b0;
                break;
            end
            n_busy++;
            if (en_dout) begin
                n_en++;
                if (int'(addr_dout) % (N+1) == 0) n_col0++;
            end
            if (step_valid && step_ready)
                got.push_back('{int'(step_i), int'(step_j), step_dir});
            if (done) n_done++;
            @(posedge clk);
            #1;
        end
        if (tmo) chk("run_timeout", 1, 0);
    endtask

    task automatic compare(input int scen, input string nm);
        int k;
        k = 0;
        foreach (tbl[t]) begin
            if (tbl[t].scen == scen) begin
                if (k < got.size()) begin
                    chk($sformatf("%s_i%0d", nm, k), got[k].i, tbl[t].i);
                    chk($sformatf("%s_j%0d", nm, k), got[k].j, tbl[t].j);
                    chk($sformatf("%s_d%0d", nm, k), int'(got[k].d), int'(tbl[t].d));
                end
                k++;
            end
        end
        chk({nm, "_nsteps"}, got.size(), k);
    endtask

    initial begin
        int cnt;
        int seen;

        for (int s = 5; s >= 1; s--) tbl.push_back('{0, s, s, DIAG});
        tbl.push_back('{1, 5, 5, UP});
        tbl.push_back('{1, 4, 5, LEFT});
        for (int s = 4; s >= 1; s--) tbl.push_back('{1, s, s, DIAG});
        for (int s = 5; s >= 1; s--) tbl.push_back('{2, 5, s, LEFT});
        for (int s = 5; s >= 1; s--) tbl.push_back('{2, s, 0, UP});
        for (int s = 5; s >= 1; s--) tbl.push_back('{3, s, s, DIAG});

        fill(DIAG);
        step_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", step_valid, 0);
        chk("rst_en", en_dout, 0);
        chk("rst_addr", int'(addr_dout), 0);
        chk("rst_dir", int'(step_dir), 0);
        chk("rst_i", int'(step_i), 0);
        chk("rst_j", int'(step_j), 0);
        chk("rst_error", error, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        fill(DIAG);
        run();
        compare(0, "diag");
        chk("diag_busy_cycles", n_busy, 16);
        chk("diag_en_pulses", n_en, 5);
        chk("diag_done", n_done, 1);

        fill(DIAG);
        put(5, 5, UP);
        put(4, 5, LEFT);
        run();
        compare(1, "upleft");
        chk("upleft_done", n_done, 1);

        fill(DIAG);
        for (int j = 1; j <= 5; j++) put(5, j, LEFT);
        run();
        compare(2, "row");
        chk("row_en_pulses", n_en, 5);
        chk("row_col0_reads", n_col0, 0);
        chk("row_done", n_done, 1);

        fill(DIAG);
        put(5, 5, 3'b011);
        run();
`ifdef TRACEBACK_ERR_CHECK_EN
        chk("bad_nsteps", got.size(), 0);
        chk("bad_error", error, 1);
        chk("bad_done", n_done, 1);
        fill(DIAG);
        run();
        chk("bad_clear_error", error, 0);
        chk("bad_clear_nsteps", got.size(), 5);
`else
        compare(3, "bad");
        chk("bad_error", error, 0);
`endif

        fill(DIAG);
        step_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 20 && !step_valid; c++) begin
            @(posedge clk);
            #1;
        end
        chk("hold_valid_seen", step_valid, 1);
        for (int c = 0; c < 3; c++) begin
            chk("hold_valid", step_valid, 1);
            chk("hold_i", int'(step_i), 5);
            chk("hold_j", int'(step_j), 5);
            chk("hold_dir", int'(step_dir), int'(DIAG));
            chk("hold_no_read", en_dout, 0);
            @(posedge clk);
            #1;
        end
        step_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 100 && busy; c++) begin
            if (done) seen++;
            @(posedge clk);
            #1;
        end
        chk("hold_done", seen, 1);
        chk("hold_idle", busy, 0);

        fill(DIAG);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (step_valid) begin
                cnt++;
                if (cnt == 3) break;
            end
            @(posedge clk);
            #1;
        end
        chk("mid_third_emit", cnt, 3);
        chk("mid_third_i", int'(step_i), 3);
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", step_valid, 0);
        chk("mid_en", en_dout, 0);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("mid_no_done_or_busy", seen, 0);
        run();
        compare(0, "restart");
        chk("restart_done", n_done, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/traceback_unit.md
TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 SHALL have parameter N, default 5: sequence length; the matrix is (N+1)x(N+1).
REQ-002 SHALL have derived parameter addr_lenght, equal to $clog2((N+1)*(N+1)-1); address buses are addr_lenght+1 bits wide.
REQ-003 SHALL have derived parameter IW, equal to $clog2(N+1): index width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that launches a traceback; sampled only in IDLE.
REQ-007 SHALL have port dout, input, signed 3 bits: direction code returned by the direction RAM.
REQ-008 SHALL have port en_dout, output, 1 bit: direction RAM read enable.
REQ-009 SHALL have port addr_dout, output, addr_lenght+1 bits: direction RAM read address.
REQ-010 SHALL have port step_valid, output, 1 bit: a traceback step is presented.
REQ-011 SHALL have port step_ready, input, 1 bit: the consumer accepts the step.
REQ-012 SHALL have port step_dir, output, 3 bits: direction of the presented step.
REQ-013 SHALL have port step_i, output, IW bits: row of the presented step.
REQ-014 SHALL have port step_j, output, IW bits: column of the presented step.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a traceback.
REQ-017 SHALL have port error, output, 1 bit: sticky flag for an invalid code; cleared by the next accepted start.

Function
REQ-018 SHALL use these direction codes: 3'b001 = DIAG (i-1, j-1), 3'b010 = UP (i-1), 3'b100 = LEFT (j-1).
REQ-019 SHALL compute the address as addr_dout = i*(N+1)+j, registered and held stable while en_dout=1.
REQ-020 SHALL implement FSM states IDLE, RD, CAP, EMIT and FIN.
REQ-021 SHALL go IDLE->RD on start, loading i=N and j=N; start in any other state SHALL be ignored.
REQ-022 SHALL, in RD, drive en_dout=1 for exactly one cycle with the current address, then go to CAP.
REQ-023 SHALL, in CAP, register dout into the direction register (RAM read latency of 1 cycle), then go to EMIT.
REQ-024 SHALL, in EMIT, hold step_valid=1 with stable step_dir, step_i and step_j until step_ready=1.
REQ-025 SHALL, on an accepting edge, update i and j per the direction code.
REQ-026 SHALL, after an accepting edge, go to FIN if the new (i,j)=(0,0), else to RD.
REQ-027 SHALL, when i=0 and j>0, skip the RAM read and go straight to EMIT with forced LEFT.
REQ-028 SHALL, when j=0 and i>0, skip the RAM read and go straight to EMIT with forced UP.
REQ-029 SHALL, in FIN, pulse done=1 for one cycle, then return to IDLE.
REQ-030 SHALL never decrement an index below 0: DIAG or UP at i=0, or DIAG or LEFT at j=0, is an invalid code.
REQ-031 SHALL drive step_valid=0 in every state except EMIT, and en_dout=0 in every state except RD.
REQ-032 SHALL emit at most 2N steps per traceback.

Reset
REQ-033 SHALL, on rst low, immediately force state IDLE and i=j=0 irrespective of clk.
REQ-034 SHALL, on rst low, immediately force addr_dout, en_dout, step_valid, step_dir, step_i, step_j, busy, done and error to 0 irrespective of clk.
REQ-035 SHALL abandon any traceback when reset asserts mid-operation, with no done pulse, and SHALL require a new start after release.

Configuration
REQ-036 SHALL use macro TRACEBACK_ERR_CHECK_EN to compile code checking in or out.
REQ-037 SHALL, with TRACEBACK_ERR_CHECK_EN defined, treat a non-one-hot code or an index underflow as invalid, set error, suppress the step and go to FIN.
REQ-038 SHALL, with TRACEBACK_ERR_CHECK_EN undefined, treat any invalid code as DIAG, saturate indices at 0, and tie error to 0.

Verification
REQ-039 SHALL cover: N=5, all cells DIAG, start, step_ready=1 -> 5 steps (5,5)..(1,1), each DIAG; then done; busy for 5*3+1 cycles.
REQ-040 SHALL cover: (5,5)=UP, (4,5)=LEFT, rest DIAG -> steps (5,5)UP, (4,5)LEFT, (4,4)DIAG..(1,1)DIAG; then done.
REQ-041 SHALL cover: (5,5)=LEFT repeated along row 5, then (5,0) -> forced UP x5 with no en_dout pulses for column 0; 10 steps total.
REQ-042 SHALL cover: step_ready held low 3 cycles in EMIT -> step_valid, step_dir, step_i and step_j stable for 3 cycles; no RAM read issued.
REQ-043 SHALL cover: TRACEBACK_ERR_CHECK_EN defined, (5,5)=3'b011 -> no step_valid, error=1, done pulse; the next start clears error.
REQ-044 SHALL cover: rst low during the third EMIT -> busy, step_valid and en_dout drop at once; no done; a new start restarts at (5,5).
